// File: rtl/ddr2_wdf_burst_buffer_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_wdf_burst_buffer_pkg
//   Shared definitions for the DDR2 write-data FIFO:
//     - default data/mask widths and the burst-length-derived words per burst
//     - DDR2_WDF_ADDR_W(depth): FIFO address width, i.e. log2(depth)
//     - wdf_op_e: the push/pop combination seen in one clock
//     - beat_width(): width of the beat counter, never narrower than 1 bit
//   Optional feature macro used by the block: DDR2_WDF_MASK_EN (byte-mask
//   storage). It is not referenced in this file.
// ----------------------------------------------------------------------------
`ifndef DDR2_WDF_ADDR_W
`define DDR2_WDF_ADDR_W(depth) $clog2(depth)
`endif

package ddr2_wdf_burst_buffer_pkg;

    // Board-level defaults: x16 device, BL4 (two {rise,fall} words per burst).
    localparam int DDR2_DQ_WIDTH     = 16;
    localparam int DDR2_DM_WIDTH     = 2;
    localparam int DDR2_BURST_WORDS  = 2;
    localparam int DDR2_WDF_DEPTH    = 16;
    localparam int DDR2_AFULL_MARGIN = 4;

    // Encoding is {pop, push} so the accepted strobes can be cast directly.
    typedef enum logic [1:0] {
        WDF_IDLE = 2'b00,
        WDF_PUSH = 2'b01,
        WDF_POP  = 2'b10,
        WDF_BOTH = 2'b11
    } wdf_op_e;

    // A single-word burst still needs a 1-bit counter to hold a legal type.
    function automatic int beat_width(input int burst_words);
        return (burst_words > 1) ? $clog2(burst_words) : 1;
    endfunction

endpackage

// File: rtl/ddr2_wdf_ram.sv
// ----------------------------------------------------------------------------
// ddr2_wdf_ram
//   Simple dual-port storage for the write-data FIFO. Writes are synchronous;
//   the read is registered straight into the output stage, so the read port
//   doubles as the wdf_data/mask_data register and holds between reads.
//   Ports:
//     clk        in   controller clock
//     reset      in   asynchronous active-high reset (output register only)
//     i_wr_en    in   write strobe
//     i_wr_addr  in   write address
//     i_wr_data  in   write word
//     i_rd_en    in   read strobe (loads the output register)
//     i_rd_addr  in   read address
//     o_rd_data  out  registered read word, 0 after reset
// ----------------------------------------------------------------------------
module ddr2_wdf_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int ADDR_W = `DDR2_WDF_ADDR_W(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Storage is deliberately left unreset so it can map onto RAM primitives.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output stage: the popped word lands here one clock after the pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ddr2_wdf_burst_buffer.sv
// ----------------------------------------------------------------------------
// ddr2_wdf_burst_buffer
//   Write-data FIFO between the user write interface and the DDR2 write
//   datapath. Buffers {rise,fall} data (and optionally mask) words, hands them
//   to the write datapath one per pop with a 1-cycle registered latency,
//   marks the last word of each burst, signals almost-full back-pressure and
//   keeps sticky overflow/underrun flags.
//   Optional feature: define DDR2_WDF_MASK_EN to store the byte mask with the
//   data; otherwise the mask input is ignored and mask_data is 0.
//   Ports:
//     clk            in   controller clock, all logic on posedge
//     reset          in   asynchronous active-high reset
//     app_wdf_wren   in   push one word
//     app_wdf_data   in   write data {rise,fall}
//     app_mask_data  in   byte mask {rise,fall}, 1 = masked
//     app_wdf_afull  out  count >= DEPTH-AFULL_MARGIN
//     ctrl_wdf_rden  in   pop one word
//     wdf_data       out  registered popped data
//     mask_data      out  registered popped mask (0 without mask storage)
//     wdf_burst_rdy  out  count >= BURST_WORDS
//     wdf_last_beat  out  registered, set with the pop of a burst's last word
//     wdf_overflow   out  sticky, push while full
//     wdf_underrun   out  sticky, pop while empty
// ----------------------------------------------------------------------------
module ddr2_wdf_burst_buffer
    import ddr2_wdf_burst_buffer_pkg::*;
#(
    parameter int DQ_WIDTH     = DDR2_DQ_WIDTH,
    parameter int DM_WIDTH     = DDR2_DM_WIDTH,
    parameter int DEPTH        = DDR2_WDF_DEPTH,
    parameter int AFULL_MARGIN = DDR2_AFULL_MARGIN,
    parameter int BURST_WORDS  = DDR2_BURST_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  app_wdf_wren,
    input  logic [2*DQ_WIDTH-1:0] app_wdf_data,
    input  logic [2*DM_WIDTH-1:0] app_mask_data,
    output logic                  app_wdf_afull,
    input  logic                  ctrl_wdf_rden,
    output logic [2*DQ_WIDTH-1:0] wdf_data,
    output logic [2*DM_WIDTH-1:0] mask_data,
    output logic                  wdf_burst_rdy,
    output logic                  wdf_last_beat,
    output logic                  wdf_overflow,
    output logic                  wdf_underrun
);

    localparam int WORD_W = 2 * DQ_WIDTH;
    localparam int MASK_W = 2 * DM_WIDTH;
    localparam int ADDR_W = `DDR2_WDF_ADDR_W(DEPTH);
    localparam int BEAT_W = beat_width(BURST_WORDS);
`ifdef DDR2_WDF_MASK_EN
    localparam int RAM_W  = WORD_W + MASK_W;
`else
    localparam int RAM_W  = WORD_W;
`endif

    localparam logic [ADDR_W:0]   C_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_AFULL     = (ADDR_W + 1)'(DEPTH - AFULL_MARGIN);
    localparam logic [ADDR_W:0]   C_BURST     = (ADDR_W + 1)'(BURST_WORDS);
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BURST_WORDS - 1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [BEAT_W-1:0] r_beat;
    logic              r_last_beat;
    logic              r_overflow;
    logic              r_underrun;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    wdf_op_e           w_op;
    logic [ADDR_W:0]   w_count_nxt;
    logic [RAM_W-1:0]  w_ram_wdata;
    logic [RAM_W-1:0]  w_ram_rdata;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Acceptance uses only the registered count: a full FIFO refuses a push
    // even if a pop frees a slot in the same clock, and a word written into an
    // empty FIFO cannot be read until the next clock (no fall-through).
    assign w_push = app_wdf_wren && !w_full;
    assign w_pop  = ctrl_wdf_rden && !w_empty;
    assign w_op   = wdf_op_e'({w_pop, w_push});

    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            WDF_PUSH: w_count_nxt = r_count + 1'b1;
            WDF_POP:  w_count_nxt = r_count - 1'b1;
            default:  w_count_nxt = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // Beat tracking: last_beat is a one-clock marker aligned with the word it
    // describes, so it drops again on any clock without a matching pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat      <= '0;
            r_last_beat <= 1'b0;
        end else begin
            r_last_beat <= w_pop && (r_beat == C_LAST_BEAT);
            if (w_pop) begin
                r_beat <= (r_beat == C_LAST_BEAT) ? '0 : r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (app_wdf_wren && w_full) begin
                r_overflow <= 1'b1;
            end
            if (ctrl_wdf_rden && w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef DDR2_WDF_MASK_EN
    assign w_ram_wdata = {app_mask_data, app_wdf_data};
    assign wdf_data    = w_ram_rdata[WORD_W-1:0];
    assign mask_data   = w_ram_rdata[RAM_W-1:WORD_W];
`else
    // Without mask storage every byte is written.
    logic w_unused_mask;
    assign w_unused_mask = ^app_mask_data;
    assign w_ram_wdata   = app_wdf_data;
    assign wdf_data      = w_ram_rdata;
    assign mask_data     = '0;
`endif

    ddr2_wdf_ram #(
        .WIDTH  (RAM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_ram_wdata),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rdata)
    );

    assign app_wdf_afull = (r_count >= C_AFULL);
    assign wdf_burst_rdy = (r_count >= C_BURST);
    assign wdf_last_beat = r_last_beat;
    assign wdf_overflow  = r_overflow;
    assign wdf_underrun  = r_underrun;

endmodule

// File: tb/tb_ddr2_wdf_burst_buffer.sv
// ----------------------------------------------------------------------------
// tb_ddr2_wdf_burst_buffer
//   Self-checking bench for ddr2_wdf_burst_buffer: a fixed vector table for
//   the basic push/pop burst, hand-written sequences for the corner cases and
//   a randomized run, all compared against a queue-based model of the FIFO.
//   Honours DDR2_WDF_MASK_EN when computing the expected mask output.
// ----------------------------------------------------------------------------
module tb_ddr2_wdf_burst_buffer;

    localparam int DQ_W  = 16;
    localparam int DM_W  = 2;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;
    localparam int BW    = 2;
    localparam int DW    = 2 * DQ_W;
    localparam int MW    = 2 * DM_W;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          app_wdf_wren = 1'b0;
    logic [DW-1:0] app_wdf_data = '0;
    logic [MW-1:0] app_mask_data = '0;
    logic          app_wdf_afull;
    logic          ctrl_wdf_rden = 1'b0;
    logic [DW-1:0] wdf_data;
    logic [MW-1:0] mask_data;
    logic          wdf_burst_rdy;
    logic          wdf_last_beat;
    logic          wdf_overflow;
    logic          wdf_underrun;

    ddr2_wdf_burst_buffer #(
        .DQ_WIDTH     (DQ_W),
        .DM_WIDTH     (DM_W),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFM),
        .BURST_WORDS  (BW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .app_wdf_wren  (app_wdf_wren),
        .app_wdf_data  (app_wdf_data),
        .app_mask_data (app_mask_data),
        .app_wdf_afull (app_wdf_afull),
        .ctrl_wdf_rden (ctrl_wdf_rden),
        .wdf_data      (wdf_data),
        .mask_data     (mask_data),
        .wdf_burst_rdy (wdf_burst_rdy),
        .wdf_last_beat (wdf_last_beat),
        .wdf_overflow  (wdf_overflow),
        .wdf_underrun  (wdf_underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the FIFO contents as a queue of {mask,data} words.
    logic [DW+MW-1:0] q[$];
    logic [DW-1:0]    m_data;
    logic [MW-1:0]    m_mask;
    logic             m_last;
    logic             m_ovf;
    logic             m_und;
    int               m_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_data = '0;
        m_mask = '0;
        m_last = 1'b0;
        m_ovf  = 1'b0;
        m_und  = 1'b0;
        m_beat = 0;
    endtask

    task automatic model_clock(input bit w, input bit r, input logic [DW-1:0] d,
                               input logic [MW-1:0] mk);
        logic [DW+MW-1:0] e;
        bit full;
        bit empty;
        full   = (q.size() == DEPTH);
        empty  = (q.size() == 0);
        m_last = 1'b0;
        if (r && !empty) begin
            e      = q.pop_front();
            m_data = e[DW-1:0];
`ifdef DDR2_WDF_MASK_EN
            m_mask = e[DW+MW-1:DW];
`else
            m_mask = '0;
`endif
            m_last = (m_beat == BW - 1);
            m_beat = (m_beat + 1) % BW;
        end
        if (r && empty) m_und = 1'b1;
        if (w && !full) q.push_back({mk, d});
        if (w && full) m_ovf = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".data"},  64'(wdf_data),      64'(m_data));
        chk({tag, ".mask"},  64'(mask_data),     64'(m_mask));
        chk({tag, ".last"},  64'(wdf_last_beat), 64'(m_last));
        chk({tag, ".afull"}, 64'(app_wdf_afull), 64'(q.size() >= DEPTH - AFM));
        chk({tag, ".rdy"},   64'(wdf_burst_rdy), 64'(q.size() >= BW));
        chk({tag, ".ovf"},   64'(wdf_overflow),  64'(m_ovf));
        chk({tag, ".und"},   64'(wdf_underrun),  64'(m_und));
    endtask

    // One clock: drive on the falling edge, update model on the rising edge,
    // sample 1 ns after it.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input logic [MW-1:0] mk, input bit do_chk, input string tag);
        @(negedge clk);
        app_wdf_wren  = w;
        ctrl_wdf_rden = r;
        app_wdf_data  = d;
        app_mask_data = mk;
        @(posedge clk);
        model_clock(w, r, d, mk);
        #1;
        if (do_chk) check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        app_wdf_wren  = 1'b0;
        ctrl_wdf_rden = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit            w;
        bit            r;
        logic [DW-1:0] d;
        logic [DW-1:0] e_data;
        bit            e_last;
        bit            e_afull;
        bit            e_rdy;
        bit            e_ovf;
        bit            e_und;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [DW-1:0] exp_mask_d;
        logic [MW-1:0] exp_mask;

        tbl[0] = '{1'b1, 1'b0, 32'hA5A5_5A5A, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'hFFFF_0000, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0,         32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0,         32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,         32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Basic burst from the table, expected values written out by hand.
        do_reset("rst1");
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d, '0, 1'b0, "t1");
            chk($sformatf("t1[%0d].data", i),  64'(wdf_data),      64'(tbl[i].e_data));
            chk($sformatf("t1[%0d].last", i),  64'(wdf_last_beat), 64'(tbl[i].e_last));
            chk($sformatf("t1[%0d].afull", i), 64'(app_wdf_afull), 64'(tbl[i].e_afull));
            chk($sformatf("t1[%0d].rdy", i),   64'(wdf_burst_rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("t1[%0d].ovf", i),   64'(wdf_overflow),  64'(tbl[i].e_ovf));
            chk($sformatf("t1[%0d].und", i),   64'(wdf_underrun),  64'(tbl[i].e_und));
        end

        // Overflow: 17 pushes into a 16-deep FIFO, then drain 17.
        do_reset("rst2");
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 32'h1000_0000 + 32'(i), '0, 1'b1, "t2push");
            if (i == 10) chk("t2.afull_at_11", 64'(app_wdf_afull), 64'd0);
            if (i == 11) chk("t2.afull_at_12", 64'(app_wdf_afull), 64'd1);
        end
        chk("t2.overflow", 64'(wdf_overflow), 64'd1);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, '0, '0, 1'b1, "t2pop");
            if (i == 15) chk("t2.last_word", 64'(wdf_data), 64'h1000_000F);
        end
        chk("t2.underrun_after_drain", 64'(wdf_underrun), 64'd1);

        // Pop on empty right after reset.
        do_reset("rst3");
        step(1'b0, 1'b1, '0, '0, 1'b1, "t3pop");
        chk("t3.data_held_0", 64'(wdf_data), 64'd0);
        chk("t3.underrun", 64'(wdf_underrun), 64'd1);
        step(1'b1, 1'b0, 32'h1234_5678, '0, 1'b1, "t3push");
        step(1'b0, 1'b1, '0, '0, 1'b1, "t3pop2");
        chk("t3.rdptr_unmoved", 64'(wdf_data), 64'h1234_5678);

        // Steady state at half full with simultaneous push and pop across the wrap.
        do_reset("rst4");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom, '0, 1'b1, "t4fill");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom, '0, 1'b1, "t4pp");
        chk("t4.no_overflow", 64'(wdf_overflow), 64'd0);

        // Reset in the middle of a burst.
        do_reset("rst5");
        step(1'b1, 1'b0, 32'hDEAD_0001, '0, 1'b1, "t5push");
        step(1'b1, 1'b0, 32'hDEAD_0002, '0, 1'b1, "t5push");
        step(1'b0, 1'b1, '0, '0, 1'b1, "t5pop");
        @(negedge clk);
        app_wdf_wren  = 1'b0;
        ctrl_wdf_rden = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5.data_cleared", 64'(wdf_data), 64'd0);
        chk("t5.rdy_cleared", 64'(wdf_burst_rdy), 64'd0);
        chk("t5.last_cleared", 64'(wdf_last_beat), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 32'hBEEF_0001, '0, 1'b1, "t5push2");
        step(1'b1, 1'b0, 32'hBEEF_0002, '0, 1'b1, "t5push2");
        step(1'b0, 1'b1, '0, '0, 1'b1, "t5pop2");
        chk("t5.beat0_not_last", 64'(wdf_last_beat), 64'd0);
        step(1'b0, 1'b1, '0, '0, 1'b1, "t5pop2");
        chk("t5.beat1_last", 64'(wdf_last_beat), 64'd1);

        // Mask path.
        do_reset("rst6");
        step(1'b1, 1'b0, 32'hCAFE_F00D, 4'b0010, 1'b1, "t6push");
        step(1'b0, 1'b1, '0, '0, 1'b1, "t6pop");
        exp_mask_d = '0;
`ifdef DDR2_WDF_MASK_EN
        exp_mask = 4'b0010;
`else
        exp_mask = 4'b0000;
`endif
        chk("t6.mask", 64'(mask_data), 64'(exp_mask));
        chk("t6.data", 64'(wdf_data), 64'h0000_0000_CAFE_F00D | 64'(exp_mask_d));

        // Randomized traffic, with one asynchronous reset partway through.
        do_reset("rst7");
        for (int i = 0; i < 600; i++) begin
            bit w;
            bit r;
            if (i == 300) do_reset("rst7mid");
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 99) < 65);
                r = ($urandom_range(0, 99) < 40);
            end else begin
                w = ($urandom_range(0, 99) < 40);
                r = ($urandom_range(0, 99) < 65);
            end
            step(w, r, $urandom, 4'($urandom), 1'b1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
